// File: rtl/vga_scanout.sv
// 640x480@60 VGA timing generator that scans a 40x30 monochrome framebuffer out as
// 16x16-pixel cells, reading from a shadow copy taken once per frame.
module vga_scanout #(
  parameter int          CLK_DIV   = 2,
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [1199:0] framebuffer,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Pixel-rate enable and raster counters
  logic [DIV_W-1:0] div_q, div_d;
  logic             pe;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;

  // Frame snapshot
  logic [1199:0]    shadow_q, shadow_d;
  logic             snap;
  logic             frame_start_q, frame_start_d;

  // Stage 1: cell coordinates and raw timing flags
  logic [5:0]       s1_col_q, s1_col_d;
  logic [4:0]       s1_row_q, s1_row_d;
  logic             s1_vis_q, s1_vis_d;
  logic             s1_hs_q, s1_hs_d;
  logic             s1_vs_q, s1_vs_d;

  // Stage 2: pixel colour and aligned sync
  logic [10:0]      pix_idx;
  logic             pix_bit;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;

  always_comb begin
    pe    = (div_q == DIV_LAST);
    div_d = pe ? '0 : div_q + DIV_W'(1);

    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pe) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // The shadow is reloaded at the start of the first blank line, so the visible
  // part of every frame always comes from one consistent copy.
  always_comb begin
    snap          = pe && (hcount_q == '0) && (vcount_q == V_VIS_END);
    shadow_d      = snap ? framebuffer : shadow_q;
    frame_start_d = snap;
  end

  always_comb begin
    s1_col_d = s1_col_q;
    s1_row_d = s1_row_q;
    s1_vis_d = s1_vis_q;
    s1_hs_d  = s1_hs_q;
    s1_vs_d  = s1_vs_q;
    if (pe) begin
      s1_col_d = hcount_q[9:4];
      s1_row_d = vcount_q[8:4];
      s1_vis_d = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
      s1_hs_d  = !((hcount_q >= HS_START) && (hcount_q < HS_END));
      s1_vs_d  = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    end
  end

  // row*40 built as (row<<5)+(row<<3); forced to 0 outside the visible area so
  // the index never leaves 0..1199.
  always_comb begin
    pix_idx = '0;
    if (s1_vis_q) begin
      pix_idx = {1'b0, s1_row_q, 5'b0} + {3'b0, s1_row_q, 3'b0} + {5'b0, s1_col_q};
    end
    pix_bit = shadow_q[pix_idx];
  end

  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (pe) begin
      rgb_d = s1_vis_q ? (pix_bit ? FG_COLOR : BG_COLOR) : 12'h000;
      hs_d  = s1_hs_q;
      vs_d  = s1_vs_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      shadow_q      <= '0;
      frame_start_q <= 1'b0;
      s1_col_q      <= '0;
      s1_row_q      <= '0;
      s1_vis_q      <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      rgb_q         <= 12'h000;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      shadow_q      <= shadow_d;
      frame_start_q <= frame_start_d;
      s1_col_q      <= s1_col_d;
      s1_row_q      <= s1_row_d;
      s1_vis_q      <= s1_vis_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full 640x480 timing, a reduced-geometry copy for whole-frame
// behaviour, and a CLK_DIV=1 copy, checked from a table of hand-computed pixels.
module tb_vga_scanout;

  logic          clock;
  logic          reset_n;
  logic [1199:0] fb;

  logic       a_hs, a_vs, a_fs, b_hs, b_vs, b_fs, c_hs, c_vs, c_fs;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

  int          sel;
  logic        s_hs, s_vs, s_fs;
  logic [11:0] s_rgb;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  // Instance 0: default timing. Instance 1: 80x38 raster (64x32 visible).
  // Instance 2: CLK_DIV=1, full lines, 22-line frame (16 visible lines).
  vga_scanout #(.CLK_DIV(2)) u_a (
    .clock(clock), .reset_n(reset_n), .framebuffer(fb),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .frame_start(a_fs));

  vga_scanout #(.CLK_DIV(2), .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                .V_VISIBLE(32), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_b (
    .clock(clock), .reset_n(reset_n), .framebuffer(fb),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .frame_start(b_fs));

  vga_scanout #(.CLK_DIV(1), .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_c (
    .clock(clock), .reset_n(reset_n), .framebuffer(fb),
    .vga_hs(c_hs), .vga_vs(c_vs), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
    .frame_start(c_fs));

  always_comb begin
    case (sel)
      0:       begin s_hs = a_hs; s_vs = a_vs; s_fs = a_fs; s_rgb = {a_r, a_g, a_b}; end
      1:       begin s_hs = b_hs; s_vs = b_vs; s_fs = b_fs; s_rgb = {b_r, b_g, b_b}; end
      default: begin s_hs = c_hs; s_vs = c_vs; s_fs = c_fs; s_rgb = {c_r, c_g, c_b}; end
    endcase
  end

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int g_div[3] = '{2, 2, 1};
  int g_ht[3]  = '{800, 80, 800};
  int g_vt[3]  = '{525, 38, 22};

  typedef struct {
    int          dut;
    int          frame;
    int          h;
    int          v;
    int          pat;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vt[40];
  int   nv = 0;

  function automatic logic [1199:0] pat(input int id);
    logic [1199:0] p;
    p = '0;
    case (id)
      1:       begin p[0] = 1'b1; p[43] = 1'b1; end
      2:       begin p = '1; p[0] = 1'b0; end
      3:       begin p[0] = 1'b1; p[39] = 1'b1; end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Driver tasks
  task automatic add(input int d, input int f, input int h, input int v, input int p,
                     input logic [11:0] rgb, input logic hs, input logic vs);
    vt[nv] = '{dut: d, frame: f, h: h, v: v, pat: p, rgb: rgb, hs: hs, vs: vs};
    nv++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    edges += n;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    edges = 0;
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int prev, nfall, fall0, fall1, low, vslow, rgbnz, tgt, cur, d, nfs, fs0, fs1;

  initial begin
    reset_n = 1'b0;
    fb      = '0;
    sel     = 0;

    // Reduced raster: frame 0 shows background, frame 1 shows pattern 1, the
    // framebuffer switches to pattern 2 at line 22 of frame 1, frame 2 shows it.
    add(1, 0,  0,  0, 1, 12'h000, 1, 1);
    add(1, 0, 70,  5, 1, 12'h000, 0, 1);
    add(1, 0, 50, 25, 1, 12'h000, 1, 1);
    add(1, 0, 10, 34, 1, 12'h000, 1, 0);
    add(1, 1,  0,  0, 1, 12'hFFF, 1, 1);
    add(1, 1, 16,  0, 1, 12'h000, 1, 1);
    add(1, 1, 15, 15, 1, 12'hFFF, 1, 1);
    add(1, 1,  0, 16, 1, 12'h000, 1, 1);
    add(1, 1, 48, 16, 1, 12'hFFF, 1, 1);
    add(1, 1, 63, 19, 1, 12'hFFF, 1, 1);
    add(1, 1,  3, 22, 2, 12'h000, 1, 1);
    add(1, 1, 50, 30, 2, 12'hFFF, 1, 1);
    add(1, 2,  0,  0, 2, 12'h000, 1, 1);
    add(1, 2, 16,  0, 2, 12'hFFF, 1, 1);
    add(1, 2, 63, 31, 2, 12'hFFF, 1, 1);
    add(1, 2, 64, 31, 2, 12'h000, 1, 1);
    add(1, 2, 20, 32, 2, 12'h000, 1, 1);
    add(1, 2, 79, 36, 2, 12'h000, 1, 1);
    // CLK_DIV=1, bits 0 and 39 set
    add(2, 0,   0,  0, 3, 12'h000, 1, 1);
    add(2, 0, 700,  3, 3, 12'h000, 0, 1);
    add(2, 0,  10, 18, 3, 12'h000, 1, 0);
    add(2, 1,   0,  0, 3, 12'hFFF, 1, 1);
    add(2, 1,  15,  0, 3, 12'hFFF, 1, 1);
    add(2, 1,  16,  0, 3, 12'h000, 1, 1);
    add(2, 1, 623,  5, 3, 12'h000, 1, 1);
    add(2, 1, 624,  5, 3, 12'hFFF, 1, 1);
    add(2, 1, 639, 15, 3, 12'hFFF, 1, 1);
    add(2, 1, 640, 15, 3, 12'h000, 1, 1);
    add(2, 1, 100, 16, 3, 12'h000, 1, 1);

    // Reset values on every instance
    repeat (2) @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk($sformatf("rst%0d hs", i), 32'(s_hs), 32'd1);
      chk($sformatf("rst%0d vs", i), 32'(s_vs), 32'd1);
      chk($sformatf("rst%0d rgb", i), 32'(s_rgb), 32'h000);
      chk($sformatf("rst%0d fs", i), 32'(s_fs), 32'd0);
    end
    sel = 0;
    @(negedge clock);
    reset_n = 1'b1;
    edges = 0;

    // Default timing: two lines of hsync
    prev = 1; nfall = 0; fall0 = -1; fall1 = -1; low = 0; vslow = 0; rgbnz = 0;
    for (int k = 1; k <= 3300; k++) begin
      step(1);
      #1;
      if (!s_hs) low++;
      if (prev == 1 && !s_hs) begin
        if (nfall == 0) fall0 = edges;
        else if (nfall == 1) fall1 = edges;
        nfall++;
      end
      prev = int'(s_hs);
      if (!s_vs) vslow++;
      if (s_rgb != 12'h000) rgbnz++;
    end
    chk("hs falls", 32'(nfall), 32'd2);
    chk("hs fall0 edge", 32'(fall0), 32'd1316);
    chk("hs fall1 edge", 32'(fall1), 32'd2916);
    chk("hs low clocks", 32'(low), 32'd384);
    chk("vs low early", 32'(vslow), 32'd0);
    chk("rgb nonzero count", 32'(rgbnz), 32'd0);

    // Asynchronous reset while hs is low, then a clean restart
    step(4604 - edges);
    #1;
    chk("pre-reset hs", 32'(s_hs), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst hs", 32'(s_hs), 32'd1);
    chk("async rst vs", 32'(s_vs), 32'd1);
    chk("async rst fs", 32'(s_fs), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    edges = 0;
    prev = 1; fall0 = -1;
    for (int k = 1; k <= 1400; k++) begin
      step(1);
      #1;
      if (prev == 1 && !s_hs && fall0 < 0) fall0 = edges;
      prev = int'(s_hs);
    end
    chk("restart hs fall edge", 32'(fall0), 32'd1316);

    // Table of pixel vectors
    cur = -1;
    for (int i = 0; i < nv; i++) begin
      d  = vt[i].dut;
      fb = pat(vt[i].pat);
      if (d != cur) begin
        cur = d;
        sel = d;
        do_reset();
      end
      tgt = g_div[d] * (vt[i].frame * g_ht[d] * g_vt[d] + vt[i].v * g_ht[d] + vt[i].h + 2);
      step(tgt - edges);
      #1;
      chk($sformatf("vec%0d rgb", i), 32'(s_rgb), 32'(vt[i].rgb));
      chk($sformatf("vec%0d hs", i), 32'(s_hs), 32'(vt[i].hs));
      chk($sformatf("vec%0d vs", i), 32'(s_vs), 32'(vt[i].vs));
    end

    // frame_start pulses on the reduced raster, then async reset of visible colour
    sel = 1;
    fb  = pat(2);
    do_reset();
    nfs = 0; fs0 = -1; fs1 = -1;
    for (int k = 1; k <= 11300; k++) begin
      step(1);
      #1;
      if (s_fs) begin
        if (nfs == 0) fs0 = edges;
        else if (nfs == 1) fs1 = edges;
        nfs++;
      end
    end
    chk("fs count", 32'(nfs), 32'd2);
    chk("fs first edge", 32'(fs0), 32'd5122);
    chk("fs second edge", 32'(fs1), 32'd11202);
    step(12196 - edges);
    #1;
    chk("fg before reset", 32'(s_rgb), 32'hFFF);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst rgb", 32'(s_rgb), 32'h000);

    // CLK_DIV=1: one line per 800 clocks
    sel = 2;
    do_reset();
    prev = 1; nfall = 0; fall0 = -1; fall1 = -1;
    for (int k = 1; k <= 1500; k++) begin
      step(1);
      #1;
      if (prev == 1 && !s_hs) begin
        if (nfall == 0) fall0 = edges;
        else if (nfall == 1) fall1 = edges;
        nfall++;
      end
      prev = int'(s_hs);
    end
    chk("div1 hs falls", 32'(nfall), 32'd2);
    chk("div1 fall0 edge", 32'(fall0), 32'd658);
    chk("div1 fall1 edge", 32'(fall1), 32'd1458);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
